stash_path_driver: RTL and testbench

Backend sequencer that sits on the opposite side of the stash's backend interface. It accepts one ORAM access command and presents the access leaf/PAddr/dummy levels to the stash. It pulses the scan start and streams decrypted path blocks from AES-decrypt into the stash write port. After the last block it pulses the read start, then drains the evicted path from the stash read port to AES-encrypt.

---
 rtl/stash_path_driver_pkg.sv | 20 ++
 rtl/stash_path_driver_prims.sv | 37 +++
 rtl/stash_path_driver.sv | 164 ++++++++++++++++
 tb/tb_stash_path_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stash_path_driver_pkg.sv
// Shared types for the stash path driver.
//   state_t         : sequencer states (3-bit encoding)
//   blocksOnPath()  : blocks on one ORAM path for a given bucket size and tree depth
package stash_path_driver_pkg;

  typedef enum logic [2:0] {
    ST_WaitInit  = 3'd0,
    ST_Idle      = 3'd1,
    ST_Scan      = 3'd2,
    ST_PathRead  = 3'd3,
    ST_StartRd   = 3'd4,
    ST_Writeback = 3'd5,
    ST_Done      = 3'd6
  } state_t;

  function automatic int unsigned blocksOnPath(input int unsigned z, input int unsigned l);
    return z * (l + 1);
  endfunction

endpackage

// File: rtl/stash_path_driver_prims.sv
// Small shared primitives used by the stash path driver.
//   Counter  : synchronous up-counter; Reset clears (dominates Enable).
//     Clock, Reset, Enable in; Count[Width] out.
//   Register : synchronous register with load enable; Reset clears.
//     Clock, Reset, Enable, In[Width] in; Out[Width] out.
module Counter #(
  parameter int Width = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  output logic [Width-1:0] Count
);

  always_ff @(posedge Clock) begin
    if (Reset)       Count <= '0;
    else if (Enable) Count <= Count + Width'(1);
  end

endmodule

module Register #(
  parameter int Width = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [Width-1:0] In,
  output logic [Width-1:0] Out
);

  always_ff @(posedge Clock) begin
    if (Reset)       Out <= '0;
    else if (Enable) Out <= In;
  end

endmodule

// File: rtl/stash_path_driver.sv
// Backend sequencer for the stash. Accepts one ORAM access command, presents
// the latched leaf/PAddr/dummy flag to the stash, pulses scan start, streams
// decrypted path blocks into the stash write port, pulses read start, then
// drains the evicted path from the stash read port to the encrypt engine.
//   Cmd*        : command in (valid/ready)
//   Access*     : latched command, held until the next accept
//   Start*      : one-cycle stash operation pulses
//   Dec*/Write* : decrypt -> stash pass-through (zero latency)
//   Read*/Enc*  : stash -> encrypt pass-through (zero latency)
//   AccessDone  : one-cycle pulse when writeback finishes; Busy while active
module stash_path_driver
  import stash_path_driver_pkg::*;
#(
  parameter int ORAML        = 32,
  parameter int ORAMU        = 32,
  parameter int DataWidth    = 512,
  parameter int ORAMZ        = 4,
  parameter int BlocksOnPath = int'(blocksOnPath(ORAMZ, ORAML)),
  parameter int BCWidth      = $clog2(BlocksOnPath + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 StashResetDone,
  input  logic [ORAML-1:0]     CmdLeaf,
  input  logic [ORAMU-1:0]     CmdPAddr,
  input  logic                 CmdIsDummy,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  output logic [ORAML-1:0]     AccessLeaf,
  output logic [ORAMU-1:0]     AccessPAddr,
  output logic                 AccessIsDummy,
  output logic                 StartScanOperation,
  output logic                 StartReadOperation,
  input  logic [DataWidth-1:0] DecData,
  input  logic [ORAMU-1:0]     DecPAddr,
  input  logic [ORAML-1:0]     DecLeaf,
  input  logic                 DecValid,
  output logic                 DecReady,
  output logic [DataWidth-1:0] WriteData,
  output logic [ORAMU-1:0]     WritePAddr,
  output logic [ORAML-1:0]     WriteLeaf,
  output logic                 WriteInValid,
  input  logic                 WriteInReady,
  input  logic                 BlockWriteComplete,
  input  logic [DataWidth-1:0] ReadData,
  input  logic [ORAMU-1:0]     ReadPAddr,
  input  logic [ORAML-1:0]     ReadLeaf,
  input  logic                 ReadOutValid,
  output logic                 ReadOutReady,
  input  logic                 BlockReadComplete,
  output logic [DataWidth-1:0] EncData,
  output logic [ORAMU-1:0]     EncPAddr,
  output logic [ORAML-1:0]     EncLeaf,
  output logic                 EncValid,
  input  logic                 EncReady,
  output logic                 AccessDone,
  output logic                 Busy
);

  localparam logic [BCWidth-1:0] LastBlock = BCWidth'(BlocksOnPath - 1);

  state_t             state, nextState;
  logic [BCWidth-1:0] blockCount;
  logic               atLast;
  logic               cntEnable;
  logic               cntClear;
  logic               accept;

  assign atLast = (blockCount == LastBlock);
  assign accept = CmdReady & CmdValid;

  // Data fields pass straight through; only the handshakes are state-gated.
  assign WriteData  = DecData;
  assign WritePAddr = DecPAddr;
  assign WriteLeaf  = DecLeaf;
  assign EncData    = ReadData;
  assign EncPAddr   = ReadPAddr;
  assign EncLeaf    = ReadLeaf;

  Register #(.Width(ORAML + ORAMU + 1)) accessReg (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (accept),
    .In     ({CmdLeaf, CmdPAddr, CmdIsDummy}),
    .Out    ({AccessLeaf, AccessPAddr, AccessIsDummy})
  );

  // Counter is shared by both path phases; it is cleared on the final
  // complete pulse so each phase starts from zero and never reaches BlocksOnPath.
  Counter #(.Width(BCWidth)) blockCounter (
    .Clock  (Clock),
    .Reset  (cntClear),
    .Enable (cntEnable),
    .Count  (blockCount)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_WaitInit;
    else       state <= nextState;
  end

  // Everything is gated by Reset so control outputs are quiet in the reset
  // cycle itself, not only from the following cycle.
  always_comb begin
    nextState          = state;
    CmdReady           = 1'b0;
    StartScanOperation = 1'b0;
    StartReadOperation = 1'b0;
    DecReady           = 1'b0;
    WriteInValid       = 1'b0;
    ReadOutReady       = 1'b0;
    EncValid           = 1'b0;
    AccessDone         = 1'b0;
    Busy               = 1'b0;
    cntEnable          = 1'b0;
    cntClear           = Reset;
    if (!Reset) begin
      Busy = (state != ST_Idle) && (state != ST_WaitInit);
      case (state)
        ST_WaitInit: if (StashResetDone) nextState = ST_Idle;
        ST_Idle: begin
          CmdReady = 1'b1;
          if (CmdValid) nextState = ST_Scan;
        end
        ST_Scan: begin
          StartScanOperation = 1'b1;
          nextState          = ST_PathRead;
        end
        ST_PathRead: begin
          WriteInValid = DecValid;
          DecReady     = WriteInReady;
          if (BlockWriteComplete) begin
            cntEnable = 1'b1;
            if (atLast) begin
              cntClear  = 1'b1;
              nextState = ST_StartRd;
            end
          end
        end
        ST_StartRd: begin
          StartReadOperation = 1'b1;
          nextState          = ST_Writeback;
        end
        ST_Writeback: begin
          EncValid     = ReadOutValid;
          ReadOutReady = EncReady;
          if (BlockReadComplete) begin
            cntEnable = 1'b1;
            if (atLast) begin
              cntClear  = 1'b1;
              nextState = ST_Done;
            end
          end
        end
        ST_Done: begin
          AccessDone = 1'b1;
          nextState  = ST_Idle;
        end
        default: nextState = ST_WaitInit;
      endcase
    end
  end

endmodule

// File: tb/tb_stash_path_driver.sv
// Self-checking bench for stash_path_driver (ORAML=3, ORAMZ=4 -> 16 blocks,
// two beats per block). The bench plays the decrypt, stash and encrypt sides.
module tb_stash_path_driver;

  localparam int L  = 3;
  localparam int U  = 16;
  localparam int DW = 32;
  localparam int Z  = 4;
  localparam int NB = Z * (L + 1);
  localparam int BUDGET = 2000;

  logic          Clock, Reset, StashResetDone;
  logic [L-1:0]  CmdLeaf;
  logic [U-1:0]  CmdPAddr;
  logic          CmdIsDummy, CmdValid, CmdReady;
  logic [L-1:0]  AccessLeaf;
  logic [U-1:0]  AccessPAddr;
  logic          AccessIsDummy, StartScanOperation, StartReadOperation;
  logic [DW-1:0] DecData;
  logic [U-1:0]  DecPAddr;
  logic [L-1:0]  DecLeaf;
  logic          DecValid, DecReady;
  logic [DW-1:0] WriteData;
  logic [U-1:0]  WritePAddr;
  logic [L-1:0]  WriteLeaf;
  logic          WriteInValid, WriteInReady, BlockWriteComplete;
  logic [DW-1:0] ReadData;
  logic [U-1:0]  ReadPAddr;
  logic [L-1:0]  ReadLeaf;
  logic          ReadOutValid, ReadOutReady, BlockReadComplete;
  logic [DW-1:0] EncData;
  logic [U-1:0]  EncPAddr;
  logic [L-1:0]  EncLeaf;
  logic          EncValid, EncReady, AccessDone, Busy;

  stash_path_driver #(.ORAML(L), .ORAMU(U), .DataWidth(DW), .ORAMZ(Z)) dut (
    .Clock(Clock), .Reset(Reset), .StashResetDone(StashResetDone),
    .CmdLeaf(CmdLeaf), .CmdPAddr(CmdPAddr), .CmdIsDummy(CmdIsDummy),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .AccessLeaf(AccessLeaf), .AccessPAddr(AccessPAddr), .AccessIsDummy(AccessIsDummy),
    .StartScanOperation(StartScanOperation), .StartReadOperation(StartReadOperation),
    .DecData(DecData), .DecPAddr(DecPAddr), .DecLeaf(DecLeaf),
    .DecValid(DecValid), .DecReady(DecReady),
    .WriteData(WriteData), .WritePAddr(WritePAddr), .WriteLeaf(WriteLeaf),
    .WriteInValid(WriteInValid), .WriteInReady(WriteInReady),
    .BlockWriteComplete(BlockWriteComplete),
    .ReadData(ReadData), .ReadPAddr(ReadPAddr), .ReadLeaf(ReadLeaf),
    .ReadOutValid(ReadOutValid), .ReadOutReady(ReadOutReady),
    .BlockReadComplete(BlockReadComplete),
    .EncData(EncData), .EncPAddr(EncPAddr), .EncLeaf(EncLeaf),
    .EncValid(EncValid), .EncReady(EncReady),
    .AccessDone(AccessDone), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic v;
    logic r;
    logic expValid;
    logic expReady;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chkControlsZero(input string tag);
    chk({tag, "_CmdReady"}, CmdReady, 0);
    chk({tag, "_StartScan"}, StartScanOperation, 0);
    chk({tag, "_StartRead"}, StartReadOperation, 0);
    chk({tag, "_DecReady"}, DecReady, 0);
    chk({tag, "_WriteInValid"}, WriteInValid, 0);
    chk({tag, "_ReadOutReady"}, ReadOutReady, 0);
    chk({tag, "_EncValid"}, EncValid, 0);
    chk({tag, "_AccessDone"}, AccessDone, 0);
    chk({tag, "_Busy"}, Busy, 0);
  endtask

  // One full access. The bench tracks the expected phase by counting the
  // block-complete pulses it issues itself. rnd=0 uses fixed handshake
  // patterns so the total cycle count is known in advance.
  task automatic runAccess(input logic [L-1:0] leaf, input logic [U-1:0] paddr,
                           input logic dummy, input bit rnd, input bit holdCmd,
                           input int abortAt, output int cycles);
    int blocks, beat, i;
    logic v, r;
    logic [U-1:0] encQ[$];
    cycles = 0;

    CmdLeaf = leaf; CmdPAddr = paddr; CmdIsDummy = dummy; CmdValid = 1'b1;
    DecValid = 1'b1; WriteInReady = 1'b1; ReadOutValid = 1'b1; EncReady = 1'b1;
    #1;
    chk("idle_CmdReady", CmdReady, 1);
    chk("idle_WriteInValid", WriteInValid, 0);
    chk("idle_DecReady", DecReady, 0);
    chk("idle_EncValid", EncValid, 0);
    chk("idle_ReadOutReady", ReadOutReady, 0);
    chk("idle_Busy", Busy, 0);
    tick(); cycles++;

    if (holdCmd) begin
      CmdLeaf = ~leaf; CmdPAddr = ~paddr; CmdIsDummy = ~dummy;
    end else CmdValid = 1'b0;
    #1;
    chk("scan_pulse", StartScanOperation, 1);
    chk("scan_AccessLeaf", AccessLeaf, leaf);
    chk("scan_AccessPAddr", AccessPAddr, paddr);
    chk("scan_AccessIsDummy", AccessIsDummy, dummy);
    chk("scan_CmdReady", CmdReady, 0);
    chk("scan_WriteInValid", WriteInValid, 0);
    chk("scan_Busy", Busy, 1);
    tick(); cycles++;

    blocks = 0; beat = 0; i = 0;
    while (blocks < NB) begin
      if (i >= BUDGET) begin
        checks++; errors++;
        $display("FAIL pathread_timeout: got %0d blocks expected %0d", blocks, NB);
        return;
      end
      if (rnd) begin
        v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      end else begin
        v = tbl[i % 4].v; r = tbl[i % 4].r;
      end
      DecValid = v; WriteInReady = r;
      DecData = $urandom; DecPAddr = U'(blocks); DecLeaf = L'($urandom);
      BlockWriteComplete = v & r & (beat == 1);
      BlockReadComplete  = ($urandom_range(0, 3) == 0);
      #1;
      chk("pr_WriteInValid", WriteInValid, rnd ? v : tbl[i % 4].expValid);
      chk("pr_DecReady", DecReady, rnd ? r : tbl[i % 4].expReady);
      chk("pr_WriteData", WriteData, DecData);
      chk("pr_WritePAddr", WritePAddr, DecPAddr);
      chk("pr_WriteLeaf", WriteLeaf, DecLeaf);
      chk("pr_StartScan", StartScanOperation, 0);
      chk("pr_StartRead", StartReadOperation, 0);
      chk("pr_CmdReady", CmdReady, 0);
      chk("pr_EncValid", EncValid, 0);
      chk("pr_AccessLeaf", AccessLeaf, leaf);
      if (v & r) begin
        if (beat == 1) begin beat = 0; blocks++; end
        else beat = 1;
      end
      tick(); cycles++; i++;
    end

    BlockWriteComplete = 1'b1; BlockReadComplete = 1'b1;
    DecValid = 1'b1; WriteInReady = 1'b1; ReadOutValid = 1'b1; EncReady = 1'b1;
    #1;
    chk("startrd_pulse", StartReadOperation, 1);
    chk("startrd_WriteInValid", WriteInValid, 0);
    chk("startrd_DecReady", DecReady, 0);
    chk("startrd_EncValid", EncValid, 0);
    chk("startrd_ReadOutReady", ReadOutReady, 0);
    tick(); cycles++;

    blocks = 0; beat = 0; i = 0;
    while (blocks < NB) begin
      if (abortAt >= 0 && blocks == abortAt) break;
      if (i >= BUDGET) begin
        checks++; errors++;
        $display("FAIL writeback_timeout: got %0d blocks expected %0d", blocks, NB);
        return;
      end
      v = rnd ? 1'($urandom_range(0, 1)) : 1'((i % 3) != 0);
      r = 1'((i % 2) == 0);
      ReadOutValid = v; EncReady = r;
      ReadData = $urandom; ReadPAddr = U'(blocks); ReadLeaf = L'($urandom);
      BlockReadComplete  = v & r & (beat == 1);
      BlockWriteComplete = ($urandom_range(0, 3) == 0);
      #1;
      chk("wb_EncValid", EncValid, v);
      chk("wb_ReadOutReady", ReadOutReady, r);
      chk("wb_EncData", EncData, ReadData);
      chk("wb_EncLeaf", EncLeaf, ReadLeaf);
      chk("wb_AccessDone", AccessDone, 0);
      chk("wb_StartRead", StartReadOperation, 0);
      chk("wb_WriteInValid", WriteInValid, 0);
      chk("wb_CmdReady", CmdReady, 0);
      chk("wb_AccessIsDummy", AccessIsDummy, dummy);
      if (v & r) begin
        if (beat == 1) begin encQ.push_back(EncPAddr); beat = 0; blocks++; end
        else beat = 1;
      end
      tick(); cycles++; i++;
    end

    if (abortAt >= 0) begin
      Reset = 1'b1; StashResetDone = 1'b0; CmdValid = 1'b1;
      ReadOutValid = 1'b1; EncReady = 1'b1; BlockReadComplete = 1'b1;
      #1;
      chkControlsZero("inreset");
      tick();
      Reset = 1'b0;
      #1;
      chkControlsZero("postreset");
      chk("postreset_AccessLeaf", AccessLeaf, 0);
      chk("postreset_AccessPAddr", AccessPAddr, 0);
      chk("postreset_AccessIsDummy", AccessIsDummy, 0);
      for (int k = 0; k < 20; k++) begin
        tick();
        BlockReadComplete  = 1'($urandom_range(0, 1));
        BlockWriteComplete = 1'($urandom_range(0, 1));
        #1;
        chk("abort_StartRead", StartReadOperation, 0);
        chk("abort_AccessDone", AccessDone, 0);
        chk("abort_CmdReady", CmdReady, 0);
        chk("abort_Busy", Busy, 0);
      end
      BlockReadComplete = 1'b0; BlockWriteComplete = 1'b0; CmdValid = 1'b0;
      cycles = -1;
      return;
    end

    chk("enc_count", encQ.size(), NB);
    foreach (encQ[k]) chk("enc_order", encQ[k], k);

    BlockReadComplete = 1'b0; BlockWriteComplete = 1'b0;
    ReadOutValid = 1'b1; EncReady = 1'b1;
    #1;
    chk("done_pulse", AccessDone, 1);
    chk("done_Busy", Busy, 1);
    chk("done_CmdReady", CmdReady, 0);
    chk("done_EncValid", EncValid, 0);
    chk("done_ReadOutReady", ReadOutReady, 0);
    tick(); cycles++;
    #1;
    chk("after_CmdReady", CmdReady, 1);
    chk("after_AccessDone", AccessDone, 0);
    chk("after_Busy", Busy, 0);
    chk("after_AccessLeaf", AccessLeaf, leaf);
  endtask

  int cReal, cDummy, cTmp;

  initial begin
    tbl[0] = '{v: 1'b1, r: 1'b1, expValid: 1'b1, expReady: 1'b1};
    tbl[1] = '{v: 1'b1, r: 1'b0, expValid: 1'b1, expReady: 1'b0};
    tbl[2] = '{v: 1'b0, r: 1'b1, expValid: 1'b0, expReady: 1'b1};
    tbl[3] = '{v: 1'b0, r: 1'b0, expValid: 1'b0, expReady: 1'b0};

    Reset = 1'b1; StashResetDone = 1'b0;
    CmdLeaf = '0; CmdPAddr = '0; CmdIsDummy = 1'b0; CmdValid = 1'b0;
    DecData = '0; DecPAddr = '0; DecLeaf = '0; DecValid = 1'b0;
    WriteInReady = 1'b0; BlockWriteComplete = 1'b0;
    ReadData = '0; ReadPAddr = '0; ReadLeaf = '0; ReadOutValid = 1'b0;
    EncReady = 1'b0; BlockReadComplete = 1'b0;

    for (int k = 0; k < 10; k++) begin
      tick();
      chk("reset_CmdReady", CmdReady, 0);
      chk("reset_Busy", Busy, 0);
    end
    Reset = 1'b0;
    tick();
    chkControlsZero("waitinit");
    chk("waitinit_AccessLeaf", AccessLeaf, 0);
    StashResetDone = 1'b1;
    #1;
    chk("init_same_cycle_CmdReady", CmdReady, 0);
    tick();
    chk("init_CmdReady", CmdReady, 1);

    // Fixed handshake patterns: 1 + 1 + 125 + 1 + 95 + 1 cycles.
    runAccess(3'd5, 16'h1234, 1'b0, 1'b0, 1'b0, -1, cReal);
    chk("real_cycles", cReal, 224);
    runAccess(3'd5, 16'h1234, 1'b1, 1'b0, 1'b0, -1, cDummy);
    chk("dummy_cycles", cDummy, cReal);

    runAccess(3'd2, 16'h00AB, 1'b0, 1'b1, 1'b1, -1, cTmp);
    runAccess(3'd6, 16'hBEEF, 1'b1, 1'b1, 1'b0, -1, cTmp);
    for (int n = 0; n < 3; n++)
      runAccess(L'($urandom), U'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1, cTmp);

    runAccess(3'd7, 16'h5A5A, 1'b0, 1'b1, 1'b0, 7, cTmp);
    StashResetDone = 1'b1;
    tick();
    chk("reinit_CmdReady", CmdReady, 1);
    chk("reinit_Busy", Busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
